seg7_scan_capture: RTL and testbench
====================================

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive identical samples required before a digit is captured; legal range 2..255.
REQ-002 clk  input  1  single clock; every register in the block is clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 anodes  input  4  multiplexed display digit enables, active-low; anodes[i] low selects digit i.
REQ-005 cathodes  input  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}, cathodes[0]=a.
REQ-006 err_clr  input  1  synchronous clear of err.
REQ-007 digits  output  16  decoded hex values; digit i occupies digits[4i+3:4i].
REQ-008 digit_valid  output  4  bit i set when the last capture of digit i was a legal glyph.
REQ-009 blank  output  4  bit i set when the last capture of digit i was all segments off.
REQ-010 frame_valid  output  1  one-cycle pulse when all four digits have been captured since the previous pulse.
REQ-011 err  output  1  sticky flag, set by any illegal glyph capture.

Function
REQ-012 anodes and cathodes SHALL be registered once on entry; all later logic SHALL use only the registered sample.
REQ-013 A sample is "single-active" when exactly one anodes bit is 0; all other anode values SHALL be treated as no-digit.
REQ-014 FSM states: IDLE (no-digit), DWELL (counting a single-active sample), HELD (captured, waiting for change).
REQ-015 IDLE->DWELL on a single-active sample, with the counter loaded to 1; DWELL->IDLE on no-digit.
REQ-016 In DWELL, a sample differing from the previous one SHALL reload the counter to 1 and remain in DWELL.
REQ-017 In DWELL, an identical sample SHALL increment the counter; on the edge where the count reaches STABLE_CYCLES, the block SHALL capture and enter HELD.
REQ-018 HELD SHALL hold with no re-capture while the sample is unchanged; any change SHALL exit to DWELL (counter=1) or IDLE, per REQ-013.
REQ-019 Capture of digit i SHALL update digits[4i+3:4i], digit_valid[i] and blank[i] on the capture edge; other digits SHALL be untouched.
REQ-020 Legal glyph: nibble = decoded value, digit_valid[i]=1, blank[i]=0.
REQ-021 Blank (7'h7F): nibble = 0, digit_valid[i]=1, blank[i]=1.
REQ-022 Illegal glyph: nibble is held, digit_valid[i]=0, blank[i]=0, err set.
REQ-023 Glyphs are standard hex with lowercase b and d; examples: 0=7'b1000000, 1=7'b1111001, 4=7'b0011001, 8=7'b0000000, A=7'b0001000.
REQ-024 A 4-bit capture mask SHALL record captured digit indices, covering legal, blank and illegal captures.
REQ-025 When a capture completes the mask to 4'hF, frame_valid SHALL pulse on that same edge and the mask SHALL clear.
REQ-026 When err_clr and a new illegal capture occur in the same cycle, err SHALL end the cycle set.

Reset
REQ-027 While reset=0, the block SHALL force: FSM=IDLE, counter=0, mask=0, input registers=all ones, digits=16'h0000, digit_valid=0, blank=0, frame_valid=0, err=0.
REQ-028 Reset asserted mid-DWELL SHALL discard the partial count; after release, counting SHALL restart from a fresh sample.

Structure
REQ-029 Shared package seg7_pkg SHALL hold the 16 glyph constants, the blank constant and the FSM state enum.
REQ-030 One sub-module, seg7_glyph_decode, SHALL map 7-bit cathodes combinationally to {nibble, is_blank, is_legal}.

Verification (bench uses STABLE_CYCLES=4)
REQ-031 reset=0 for 3 cycles -> all outputs zero; release with anodes=4'hF -> outputs remain zero and no frame_valid pulse.
REQ-032 Scan with each anode held 8 cycles: anodes 1110/4, 1101/3, 1011/2, 0111/1 -> digits=16'h1234, digit_valid=4'hF, exactly one frame_valid pulse, on the capture edge of digit 3.
REQ-033 anodes=1110, cathodes=glyph 8 held 3 cycles, then anodes=4'hF -> no capture and digits unchanged.
REQ-034 anodes=1011, cathodes=7'b0110110 held 6 cycles -> digit_valid[2]=0, err=1; err stays 1 until err_clr=1 for one cycle.
REQ-035 anodes=4'b1100 with glyph 0 held 10 cycles -> no capture; then anodes=1110 held 4 cycles -> digits[3:0]=0, digit_valid[0]=1.
REQ-036 reset asserted at count=3 of a dwell, then released and the same pattern held -> capture occurs only after 4 new identical samples.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block: active-low glyph
// codes in {g,f,e,d,c,b,a} order and the capture FSM state encoding.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;  // lowercase b
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_D     = 7'h21;  // lowercase d
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_F     = 7'h0E;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no single digit selected
        DWELL = 2'd1,   // counting identical samples of one digit
        HELD  = 2'd2    // digit captured, waiting for the sample to change
    } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational map from an active-low segment pattern to its hex value,
// flagging the all-off pattern as blank and unknown patterns as illegal.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       is_blank,
    output logic       is_legal
);

    // Table lookup; anything not in the glyph set is reported illegal.
    always_comb begin
        nibble   = 4'h0;
        is_blank = 1'b0;
        is_legal = 1'b1;
        case (seg)
            GLYPH_0:     nibble = 4'h0;
            GLYPH_1:     nibble = 4'h1;
            GLYPH_2:     nibble = 4'h2;
            GLYPH_3:     nibble = 4'h3;
            GLYPH_4:     nibble = 4'h4;
            GLYPH_5:     nibble = 4'h5;
            GLYPH_6:     nibble = 4'h6;
            GLYPH_7:     nibble = 4'h7;
            GLYPH_8:     nibble = 4'h8;
            GLYPH_9:     nibble = 4'h9;
            GLYPH_A:     nibble = 4'hA;
            GLYPH_B:     nibble = 4'hB;
            GLYPH_C:     nibble = 4'hC;
            GLYPH_D:     nibble = 4'hD;
            GLYPH_E:     nibble = 4'hE;
            GLYPH_F:     nibble = 4'hF;
            GLYPH_BLANK: is_blank = 1'b1;
            default:     is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers the four hex digits shown on a multiplexed 7-segment display by
// sampling its anode/cathode drive and capturing each digit once it has been
// stable for STABLE_CYCLES consecutive samples.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anodes,
    input  logic [6:0]  cathodes,
    input  logic        err_clr,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        err
);
    import seg7_pkg::*;

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES);

    logic [3:0] anodes_p0, anodes_p1;
    logic [6:0] cathodes_p0, cathodes_p1;
    state_t     state, state_n;
    logic [7:0] cnt, cnt_n, cnt_inc;
    logic       capture;
    logic       active;
    logic [1:0] idx;
    logic       same;
    logic [3:0] nibble;
    logic       is_blank, is_legal;
    logic [3:0] mask, mask_upd;

    // Entry register (p0) and the previous sample (p1) used for stability compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anodes_p0   <= '1;
            cathodes_p0 <= '1;
            anodes_p1   <= '1;
            cathodes_p1 <= '1;
        end else begin
            anodes_p0   <= anodes;
            cathodes_p0 <= cathodes;
            anodes_p1   <= anodes_p0;
            cathodes_p1 <= cathodes_p0;
        end
    end

    // Exactly one low anode selects a digit; every other pattern is no-digit.
    always_comb begin
        active = 1'b1;
        idx    = 2'd0;
        case (anodes_p0)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: active = 1'b0;
        endcase
    end

    assign same     = (anodes_p0 == anodes_p1) && (cathodes_p0 == cathodes_p1);
    assign cnt_inc  = cnt + 8'd1;
    assign mask_upd = mask | (4'b0001 << idx);

    seg7_glyph_decode u_decode (
        .seg      (cathodes_p0),
        .nibble   (nibble),
        .is_blank (is_blank),
        .is_legal (is_legal)
    );

    // FSM state and stability counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; capture fires on the edge the count reaches STABLE_CYCLES.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (active) begin
                    state_n = DWELL;
                    cnt_n   = 8'd1;
                end else begin
                    cnt_n   = 8'd0;
                end
            end
            DWELL: begin
                if (!active) begin
                    state_n = IDLE;
                    cnt_n   = 8'd0;
                end else if (!same) begin
                    cnt_n   = 8'd1;
                end else if (cnt_inc == STABLE_LAST) begin
                    state_n = HELD;
                    cnt_n   = cnt_inc;
                    capture = 1'b1;
                end else begin
                    cnt_n   = cnt_inc;
                end
            end
            HELD: begin
                if (!same) begin
                    if (active) begin
                        state_n = DWELL;
                        cnt_n   = 8'd1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = 8'd0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // Capture into the selected digit slot, track the frame mask, keep err sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits      <= 16'h0000;
            digit_valid <= 4'h0;
            blank       <= 4'h0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            mask        <= 4'h0;
        end else begin
            frame_valid <= 1'b0;
            if (capture) begin
                if (is_legal) begin
                    digits[{idx, 2'b00} +: 4] <= nibble;
                    digit_valid[idx]          <= 1'b1;
                    blank[idx]                <= is_blank;
                end else begin
                    digit_valid[idx]          <= 1'b0;
                    blank[idx]                <= 1'b0;
                end
                if (mask_upd == 4'hF) begin
                    frame_valid <= 1'b1;
                    mask        <= 4'h0;
                end else begin
                    mask        <= mask_upd;
                end
            end
            // A new illegal capture wins over a simultaneous clear.
            if (capture && !is_legal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with STABLE_CYCLES=4. Stimulus pushes
// the expected output snapshot into a queue on the negedge just before the
// edge a capture must happen; an independent monitor pops and compares on
// every output change or frame_valid pulse.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  anodes;
    logic [6:0]  cathodes;
    logic        err_clr;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        err;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dv;
        logic [3:0]  blank;
        logic        fv;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   fv_count = 0;

    always #5 clk = ~clk;

    seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .anodes      (anodes),
        .cathodes    (cathodes),
        .err_clr     (err_clr),
        .digits      (digits),
        .digit_valid (digit_valid),
        .blank       (blank),
        .frame_valid (frame_valid),
        .err         (err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [3:0] dv,
                            input logic [3:0] bl, input logic fv, input logic er);
        exp_t e;
        e.digits = d;
        e.dv     = dv;
        e.blank  = bl;
        e.fv     = fv;
        e.err    = er;
        q.push_back(e);
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] c, input int n);
        anodes   = a;
        cathodes = c;
        repeat (n) @(negedge clk);
    endtask

    // Capture lands on the 5th posedge after the inputs change (entry register
    // plus four samples), so the expectation is queued after four negedges.
    task automatic hold_cap(input logic [3:0] a, input logic [6:0] c, input int n,
                            input logic [15:0] d, input logic [3:0] dv,
                            input logic [3:0] bl, input logic fv, input logic er);
        anodes   = a;
        cathodes = c;
        repeat (4) @(negedge clk);
        push_exp(d, dv, bl, fv, er);
        repeat (n - 4) @(negedge clk);
    endtask

    // Monitor: any change of the captured outputs, or a frame pulse, consumes one expectation.
    initial begin : monitor
        logic [24:0] prev, cur;
        exp_t e;
        prev = '0;
        forever begin
            @(posedge clk);
            #2;
            cur = {digits, digit_valid, blank, err};
            if (frame_valid) fv_count++;
            if (!reset) begin
                prev = cur;
            end else if (frame_valid || cur != prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got digits=%h dv=%b blank=%b fv=%b err=%b required no change",
                             digits, digit_valid, blank, frame_valid, err);
                end else begin
                    e = q.pop_front();
                    if (digits !== e.digits || digit_valid !== e.dv || blank !== e.blank ||
                        frame_valid !== e.fv || err !== e.err) begin
                        errors++;
                        $display("FAIL capture_event: got digits=%h dv=%b blank=%b fv=%b err=%b required digits=%h dv=%b blank=%b fv=%b err=%b",
                                 digits, digit_valid, blank, frame_valid, err,
                                 e.digits, e.dv, e.blank, e.fv, e.err);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset    = 1'b0;
        anodes   = 4'hF;
        cathodes = 7'h7F;
        err_clr  = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("reset_digits", digits, 16'h0000);
        chk("reset_dv", {12'h0, digit_valid}, 16'h0);
        chk("reset_blank", {12'h0, blank}, 16'h0);
        chk("reset_fv", {15'h0, frame_valid}, 16'h0);
        chk("reset_err", {15'h0, err}, 16'h0);

        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_digits", digits, 16'h0000);
        chk("idle_fv_count", 16'(fv_count), 16'd0);

        // Full scan 4,3,2,1 -> 1234 with one frame pulse on digit 3 capture
        hold_cap(4'b1110, 7'h19, 8, 16'h0004, 4'b0001, 4'b0000, 1'b0, 1'b0);
        hold_cap(4'b1101, 7'h30, 8, 16'h0034, 4'b0011, 4'b0000, 1'b0, 1'b0);
        hold_cap(4'b1011, 7'h24, 8, 16'h0234, 4'b0111, 4'b0000, 1'b0, 1'b0);
        hold_cap(4'b0111, 7'h79, 8, 16'h1234, 4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("scan_fv_count", 16'(fv_count), 16'd1);

        // Dwell one sample short of the threshold: no capture
        hold(4'b1110, 7'h00, 3);
        hold(4'hF, 7'h7F, 5);
        chk("short_dwell_digits", digits, 16'h1234);

        // Illegal glyph on digit 2: nibble held, valid dropped, err set and sticky
        hold_cap(4'b1011, 7'h36, 6, 16'h1234, 4'b1011, 4'b0000, 1'b0, 1'b1);
        hold(4'hF, 7'h7F, 4);
        chk("err_sticky", {15'h0, err}, 16'h1);
        err_clr = 1'b1;
        push_exp(16'h1234, 4'b1011, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        err_clr = 1'b0;
        hold(4'hF, 7'h7F, 2);

        // Two anodes low is no-digit; then a clean digit 0 glyph
        hold(4'b1100, 7'h40, 10);
        hold_cap(4'b1110, 7'h40, 4, 16'h1230, 4'b1011, 4'b0000, 1'b0, 1'b0);

        // Blank on digit 1, then A on digit 3 completes the frame (mask 0100|0001|0010|1000)
        hold_cap(4'b1101, 7'h7F, 8, 16'h1200, 4'b1011, 4'b0010, 1'b0, 1'b0);
        hold_cap(4'b0111, 7'h08, 8, 16'hA200, 4'b1011, 4'b0010, 1'b1, 1'b0);
        chk("second_frame_count", 16'(fv_count), 16'd2);

        // Reset at count=3 of a dwell on digit 0 showing lowercase d
        anodes   = 4'b1110;
        cathodes = 7'h21;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_digits", digits, 16'h0000);
        chk("midreset_dv", {12'h0, digit_valid}, 16'h0);
        chk("midreset_blank", {12'h0, blank}, 16'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        push_exp(16'h000D, 4'b0001, 4'b0000, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // Illegal capture with err_clr on the same edge: err must end set
        anodes   = 4'b1101;
        cathodes = 7'h36;
        repeat (4) @(negedge clk);
        err_clr = 1'b1;
        push_exp(16'h000D, 4'b0001, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);

        hold(4'hF, 7'h7F, 4);
        chk("final_err", {15'h0, err}, 16'h1);
        chk("final_fv_count", 16'(fv_count), 16'd2);
        chk("queue_drained", 16'(q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
